mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage of an in-order RV32 core.
//   Accepts one execute-stage result per cycle while idle. Non-memory ops are
//   written back the next cycle. Loads and stores issue a single data-memory
//   request and wait for i_dmem_ack, with a bounded wait (ACK_TIMEOUT).
//   Misaligned or illegal-size accesses complete immediately with o_exc=01.
//   Bus timeouts complete with o_exc=10.
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_valid / o_ready             upstream handshake
//   i_mem_read, i_mem_write,
//   i_func3, i_alu_result,
//   i_store_data, i_rd,
//   i_reg_write                   op fields from the execute stage
//   o_dmem_*                      data-memory request (word address, lanes)
//   i_dmem_ack, i_dmem_rdata      data-memory response
//   o_valid, o_rd, o_reg_write,
//   o_wb_data, o_exc              write-back result (o_valid is a 1-cycle pulse)
module mem_stage #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_func3,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_store_data,
    input  logic [4:0]  i_rd,
    input  logic        i_reg_write,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_be,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_valid,
    output logic [4:0]  o_rd,
    output logic        o_reg_write,
    output logic [31:0] o_wb_data,
    output logic [1:0]  o_exc
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        ready_q, ready_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        valid_q, valid_d;
    logic [4:0]  rd_q, rd_d;
    logic        rw_q, rw_d;
    logic [31:0] wb_q, wb_d;
    logic [1:0]  exc_q, exc_d;
    // Pending-op fields held while the bus access is outstanding.
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  lane_q, lane_d;
    logic [4:0]  prd_q, prd_d;
    logic        prw_q, prw_d;

    logic        accept;
    logic        is_mem;
    logic        bad_size;
    logic        misaligned;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] lane_word;

    assign accept = i_valid && ready_q;
    assign is_mem = i_mem_read || i_mem_write;

    always_comb begin
        bad_size   = (i_func3 == 3'b011) || (i_func3 == 3'b110) || (i_func3 == 3'b111);
        misaligned = ((i_func3[1:0] == 2'b01) && i_alu_result[0]) ||
                     ((i_func3[1:0] == 2'b10) && (i_alu_result[1:0] != 2'b00));
    end

    // Load lane extraction from the registered access offset.
    always_comb begin
        lane_word = i_dmem_rdata >> {lane_q, 3'b000};
        byte_sel  = lane_word[7:0];
        half_sel  = lane_q[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
        case (f3_q)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_data = {24'd0, byte_sel};
            3'b101:  load_data = {16'd0, half_sel};
            default: load_data = i_dmem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        valid_d = 1'b0;
        rd_d    = rd_q;
        rw_d    = rw_q;
        wb_d    = wb_q;
        exc_d   = exc_q;
        f3_d    = f3_q;
        lane_d  = lane_q;
        prd_d   = prd_q;
        prw_d   = prw_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!is_mem) begin
                        valid_d = 1'b1;
                        wb_d    = i_alu_result;
                        rd_d    = i_rd;
                        rw_d    = i_reg_write;
                        exc_d   = 2'b00;
                    end else if (bad_size || misaligned) begin
                        valid_d = 1'b1;
                        wb_d    = i_alu_result;
                        rd_d    = i_rd;
                        rw_d    = 1'b0;
                        exc_d   = 2'b01;
                    end else begin
                        state_d = BUS;
                        cnt_d   = '0;
                        req_d   = 1'b1;
                        we_d    = i_mem_write;
                        addr_d  = {i_alu_result[31:2], 2'b00};
                        f3_d    = i_func3;
                        lane_d  = i_alu_result[1:0];
                        prd_d   = i_rd;
                        prw_d   = i_reg_write && !i_mem_write;
                        if (i_mem_write) begin
                            case (i_func3[1:0])
                                2'b00: begin
                                    wdata_d = {4{i_store_data[7:0]}};
                                    be_d    = 4'b0001 << i_alu_result[1:0];
                                end
                                2'b01: begin
                                    wdata_d = {2{i_store_data[15:0]}};
                                    be_d    = 4'b0011 << i_alu_result[1:0];
                                end
                                default: begin
                                    wdata_d = i_store_data;
                                    be_d    = 4'b1111;
                                end
                            endcase
                        end else begin
                            wdata_d = '0;
                            be_d    = 4'b1111;
                        end
                    end
                end
            end
            BUS: begin
                // Ack is checked first so it wins over a coincident timeout.
                if (i_dmem_ack) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    rd_d    = prd_q;
                    rw_d    = prw_q;
                    exc_d   = 2'b00;
                    wb_d    = we_q ? {addr_q[31:2], lane_q} : load_data;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    rd_d    = prd_q;
                    rw_d    = 1'b0;
                    exc_d   = 2'b10;
                    wb_d    = {addr_q[31:2], lane_q};
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            valid_q <= 1'b0;
            rd_q    <= '0;
            rw_q    <= 1'b0;
            wb_q    <= '0;
            exc_q   <= '0;
            f3_q    <= '0;
            lane_q  <= '0;
            prd_q   <= '0;
            prw_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            valid_q <= valid_d;
            rd_q    <= rd_d;
            rw_q    <= rw_d;
            wb_q    <= wb_d;
            exc_q   <= exc_d;
            f3_q    <= f3_d;
            lane_q  <= lane_d;
            prd_q   <= prd_d;
            prw_q   <= prw_d;
        end
    end

    assign o_ready      = ready_q;
    assign o_dmem_req   = req_q;
    assign o_dmem_we    = we_q;
    assign o_dmem_addr  = addr_q;
    assign o_dmem_wdata = wdata_q;
    assign o_dmem_be    = be_q;
    assign o_valid      = valid_q;
    assign o_rd         = rd_q;
    assign o_reg_write  = rw_q;
    assign o_wb_data    = wb_q;
    assign o_exc        = exc_q;

endmodule
